// File: rtl/wb_arbiter.sv
// Write-back arbiter: three sources (alu, mem, fpu) share one integer and one float
// register-file write port, each port with its own round-robin pointer.
module wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic            alu_isf,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic            mem_isf,
  input  logic [XLEN-1:0] mem_data,
  input  logic            fpu_valid,
  output logic            fpu_ready,
  input  logic [4:0]      fpu_rd,
  input  logic            fpu_isf,
  input  logic [XLEN-1:0] fpu_data,
  output logic            we,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output logic            fwe,
  output logic [4:0]      fwaddr,
  output logic [XLEN-1:0] fwdata
);

  localparam int NSRC = 3;

  logic [NSRC-1:0] valid, isf, int_req, flt_req, null_wr, int_gnt, flt_gnt, ready;
  logic [4:0]      rd   [NSRC];
  logic [XLEN-1:0] data [NSRC];

  logic [1:0]      iptr_reg, iptr_next, fptr_reg, fptr_next;
  logic            we_reg, fwe_reg;
  logic [4:0]      waddr_reg, waddr_next, fwaddr_reg, fwaddr_next;
  logic [XLEN-1:0] wdata_reg, wdata_next, fwdata_reg, fwdata_next;

  assign valid   = {fpu_valid, mem_valid, alu_valid};
  assign isf     = {fpu_isf, mem_isf, alu_isf};
  assign rd[0]   = alu_rd;
  assign rd[1]   = mem_rd;
  assign rd[2]   = fpu_rd;
  assign data[0] = alu_data;
  assign data[1] = mem_data;
  assign data[2] = fpu_data;

  // Integer x0 writes are absorbed immediately and never compete for the port.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign int_req[gi] = valid[gi] && !isf[gi] && (rd[gi] != 5'd0);
      assign flt_req[gi] = valid[gi] && isf[gi];
      assign null_wr[gi] = valid[gi] && !isf[gi] && (rd[gi] == 5'd0);
      assign ready[gi]   = rstn && (int_gnt[gi] || flt_gnt[gi] || null_wr[gi]);
    end
  endgenerate

  assign {fpu_ready, mem_ready, alu_ready} = ready;

  function automatic logic [NSRC-1:0] rr_pick(input logic [NSRC-1:0] req, input logic [1:0] ptr);
    logic [NSRC-1:0] gnt;
    logic [1:0]      idx;
    gnt = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = 2'((int'(ptr) + k) % NSRC);
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [NSRC-1:0] gnt, input logic [1:0] ptr);
    logic [1:0] nxt;
    nxt = ptr;
    if (gnt[0]) nxt = 2'd1;
    if (gnt[1]) nxt = 2'd2;
    if (gnt[2]) nxt = 2'd0;
    return nxt;
  endfunction

  assign int_gnt   = rr_pick(int_req, iptr_reg);
  assign flt_gnt   = rr_pick(flt_req, fptr_reg);
  assign iptr_next = ptr_after(int_gnt, iptr_reg);
  assign fptr_next = ptr_after(flt_gnt, fptr_reg);

  // Address/data hold their last value when a port is idle.
  always_comb begin
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    fwaddr_next = fwaddr_reg;
    fwdata_next = fwdata_reg;
    for (int s = 0; s < NSRC; s++) begin
      if (int_gnt[s]) begin
        waddr_next = rd[s];
        wdata_next = data[s];
      end
      if (flt_gnt[s]) begin
        fwaddr_next = rd[s];
        fwdata_next = data[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      iptr_reg   <= 2'd0;
      fptr_reg   <= 2'd0;
      we_reg     <= 1'b0;
      fwe_reg    <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      fwaddr_reg <= '0;
      fwdata_reg <= '0;
    end else begin
      iptr_reg   <= iptr_next;
      fptr_reg   <= fptr_next;
      we_reg     <= |int_gnt;
      fwe_reg    <= |flt_gnt;
      waddr_reg  <= waddr_next;
      wdata_reg  <= wdata_next;
      fwaddr_reg <= fwaddr_next;
      fwdata_reg <= fwdata_next;
    end
  end

  assign we     = we_reg;
  assign waddr  = waddr_reg;
  assign wdata  = wdata_reg;
  assign fwe    = fwe_reg;
  assign fwaddr = fwaddr_reg;
  assign fwdata = fwdata_reg;

endmodule
